// File: rtl/regfile_writeback.sv
// Single write-port arbiter for the integer register file: ALU results win, buffered
// long-latency results fill idle slots, and a pending scoreboard reports busy registers.
module regfile_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_lng_valid,
  input  logic [4:0]  i_lng_rd,
  input  logic [31:0] i_lng_data,
  output logic        o_lng_ready,
  input  logic        i_iss_valid,
  input  logic        i_iss_long,
  input  logic [4:0]  i_iss_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_rd_busy,
  output logic        o_hold_req,
  output logic        o_w_enable,
  output logic [4:0]  o_wd,
  output logic [31:0] o_w_data
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [4:0]       r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pending;
  logic             r_w_enable;
  logic [4:0]       r_wd;
  logic [31:0]      r_w_data;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_cand;
  logic             w_iss_set;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_pending_nxt;

  function automatic logic busy_f(input logic [4:0] q, input logic [31:0] pend,
                                  input logic we, input logic [4:0] wa);
    return (q != 5'd0) && (pend[q] || (we && (wa == q)));
  endfunction

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign w_head_rd   = r_fifo_rd[r_head];
  // rd==0 results are acknowledged but never stored
  assign w_push      = i_lng_valid && !w_full && (i_lng_rd != 5'd0);
  assign w_alu_cand  = i_alu_valid && (i_alu_rd != 5'd0);
  assign w_pop       = !i_stall && !w_alu_cand && !w_empty;
  assign w_iss_set   = i_iss_valid && i_iss_long && (i_iss_rd != 5'd0) && !i_stall;

  assign o_lng_ready = !w_full;
  assign o_hold_req  = w_full;
  assign o_w_enable  = r_w_enable;
  assign o_wd        = r_wd;
  assign o_w_data    = r_w_data;
  assign o_rs1_busy  = busy_f(i_rs1, r_pending, r_w_enable, r_wd);
  assign o_rs2_busy  = busy_f(i_rs2, r_pending, r_w_enable, r_wd);
  assign o_rd_busy   = busy_f(i_rd,  r_pending, r_w_enable, r_wd);

  // Scoreboard next state: clear the popped register, then a new issue overrides it
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (w_iss_set) begin
      w_pending_nxt[i_iss_rd] = 1'b1;
    end else begin
      w_pending_nxt[0] = 1'b0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since occupancy is tracked by r_count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= i_lng_rd;
      r_fifo_data[r_tail] <= i_lng_data;
    end
  end

  // FIFO pointers, occupancy and scoreboard
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head    <= {PTR_W{1'b0}};
      r_tail    <= {PTR_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port: ALU first, then FIFO head, otherwise idle keeping addr/data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_w_enable <= 1'b0;
      r_wd       <= 5'd0;
      r_w_data   <= 32'd0;
    end else if (!i_stall) begin
      if (w_alu_cand) begin
        r_w_enable <= 1'b1;
        r_wd       <= i_alu_rd;
        r_w_data   <= i_alu_data;
      end else if (w_pop) begin
        r_w_enable <= 1'b1;
        r_wd       <= w_head_rd;
        r_w_data   <= r_fifo_data[r_head];
      end else begin
        r_w_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed-vector bench for regfile_writeback: one task per scenario, inline checks.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic        alu_valid, lng_valid, iss_valid, iss_long;
  logic [4:0]  alu_rd, lng_rd, iss_rd, rs1, rs2, rd;
  logic [31:0] alu_data, lng_data;
  logic        lng_ready, rs1_busy, rs2_busy, rd_busy, hold_req, w_enable;
  logic [4:0]  wd;
  logic [31:0] w_data;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lng_valid(lng_valid), .i_lng_rd(lng_rd), .i_lng_data(lng_data),
    .o_lng_ready(lng_ready),
    .i_iss_valid(iss_valid), .i_iss_long(iss_long), .i_iss_rd(iss_rd),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rd_busy(rd_busy),
    .o_hold_req(hold_req), .o_w_enable(w_enable), .o_wd(wd), .o_w_data(w_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; alu_valid = 1'b0; lng_valid = 1'b0; iss_valid = 1'b0;
    iss_long = 1'b0; alu_rd = 5'd0; lng_rd = 5'd0; iss_rd = 5'd0;
    alu_data = 32'd0; lng_data = 32'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd31;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({lng_ready, hold_req, w_enable, wd, w_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: ready=%b hold=%b we=%b wd=%0d data=%h, required 1 0 0 0 0",
                 i, lng_ready, hold_req, w_enable, wd, w_data);
      end
      n_tests++;
      if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_busy cyc %0d: got %b required 000", i, {rs1_busy, rs2_busy, rd_busy});
      end
    end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; rs1 = 5'd5;
    tick();
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL alu_write: got we=%b wd=%0d data=%h required 1 5 deadbeef", w_enable, wd, w_data);
    end
    n_tests++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_busy_inflight: got %b required 1", rs1_busy);
    end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00000001;
    tick();
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if (w_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_rd0: got we=%b required 0", w_enable);
    end
    n_tests++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_busy_after: got %b required 0", rs1_busy);
    end
  endtask

  task automatic test_long();
    rs1 = 5'd7;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0; iss_long = 1'b0;
    #1;
    n_tests++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL long_busy_issue: got %b required 1", rs1_busy);
    end
    lng_valid = 1'b1; lng_rd = 5'd7; lng_data = 32'h00001234;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000AAAA;
    #1;
    n_tests++;
    if (lng_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL long_ready: got %b required 1", lng_ready);
    end
    tick();
    lng_valid = 1'b0; alu_valid = 1'b0;
    #1;
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd3, 32'h0000AAAA}) begin
      n_fail++;
      $display("FAIL long_alu_first: got we=%b wd=%0d data=%h required 1 3 0000aaaa", w_enable, wd, w_data);
    end
    n_tests++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL long_busy_queued: got %b required 1", rs1_busy);
    end
    tick();
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd7, 32'h00001234}) begin
      n_fail++;
      $display("FAIL long_write: got we=%b wd=%0d data=%h required 1 7 00001234", w_enable, wd, w_data);
    end
    n_tests++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL long_busy_outreg: got %b required 1", rs1_busy);
    end
    tick();
    n_tests++;
    if ({w_enable, rs1_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL long_done: got we/busy=%b required 00", {w_enable, rs1_busy});
    end
  endtask

  task automatic test_fill();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h00000011;
    lng_valid = 1'b1; lng_rd = 5'd10; lng_data = 32'h0000000A;
    tick();
    lng_rd = 5'd11; lng_data = 32'h0000000B; alu_data = 32'h00000012;
    tick();
    lng_valid = 1'b0;
    #1;
    n_tests++;
    if ({lng_ready, hold_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL fill_full: got ready/hold=%b required 01", {lng_ready, hold_req});
    end
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd1, 32'h00000012}) begin
      n_fail++;
      $display("FAIL fill_alu: got we=%b wd=%0d data=%h required 1 1 00000012", w_enable, wd, w_data);
    end
    alu_valid = 1'b0;
    tick();
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd10, 32'h0000000A}) begin
      n_fail++;
      $display("FAIL fill_drain1: got we=%b wd=%0d data=%h required 1 10 0000000a", w_enable, wd, w_data);
    end
    n_tests++;
    if ({lng_ready, hold_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL fill_ready_back: got ready/hold=%b required 10", {lng_ready, hold_req});
    end
    tick();
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd11, 32'h0000000B}) begin
      n_fail++;
      $display("FAIL fill_drain2: got we=%b wd=%0d data=%h required 1 11 0000000b", w_enable, wd, w_data);
    end
    tick();
    n_tests++;
    if (w_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_empty: got we=%b required 0", w_enable);
    end
  endtask

  task automatic test_stall();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h00000022;
    lng_valid = 1'b1; lng_rd = 5'd9; lng_data = 32'h00000099;
    tick();
    stall = 1'b1; alu_rd = 5'd6; alu_data = 32'h00000066;
    lng_rd = 5'd12; lng_data = 32'h000000CC;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd13; rd = 5'd13;
    for (int i = 0; i < 3; i++) begin
      tick();
      lng_valid = 1'b0;
      #1;
      n_tests++;
      if ({w_enable, wd, w_data} !== {1'b1, 5'd2, 32'h00000022}) begin
        n_fail++;
        $display("FAIL stall_frozen cyc %0d: got we=%b wd=%0d data=%h required 1 2 00000022",
                 i, w_enable, wd, w_data);
      end
      n_tests++;
      if (lng_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_push cyc %0d: ready=%b required 0 (push accepted, no pop)", i, lng_ready);
      end
    end
    stall = 1'b0; alu_valid = 1'b0; iss_valid = 1'b0; iss_long = 1'b0;
    tick();
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd9, 32'h00000099}) begin
      n_fail++;
      $display("FAIL stall_x9: got we=%b wd=%0d data=%h required 1 9 00000099", w_enable, wd, w_data);
    end
    tick();
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd12, 32'h000000CC}) begin
      n_fail++;
      $display("FAIL stall_x12: got we=%b wd=%0d data=%h required 1 12 000000cc", w_enable, wd, w_data);
    end
    tick();
    n_tests++;
    if ({w_enable, rd_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_issue_ignored: got we/rd_busy=%b required 00", {w_enable, rd_busy});
    end
  endtask

  task automatic test_set_clear_and_reset();
    rs1 = 5'd4;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    lng_valid = 1'b1; lng_rd = 5'd4; lng_data = 32'h00000044;
    tick();
    lng_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0; iss_long = 1'b0;
    #1;
    n_tests++;
    if ({w_enable, wd, w_data} !== {1'b1, 5'd4, 32'h00000044}) begin
      n_fail++;
      $display("FAIL setclr_write: got we=%b wd=%0d data=%h required 1 4 00000044", w_enable, wd, w_data);
    end
    tick();
    n_tests++;
    if ({w_enable, rs1_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL setclr_set_wins: got we/busy=%b required 01", {w_enable, rs1_busy});
    end
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h00000001;
    lng_valid = 1'b1; lng_rd = 5'd20; lng_data = 32'h00000020;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd22;
    tick();
    iss_valid = 1'b0; iss_long = 1'b0;
    lng_rd = 5'd21; lng_data = 32'h00000021;
    tick();
    lng_valid = 1'b0;
    rs2 = 5'd22; rd = 5'd20;
    #1;
    n_tests++;
    if ({hold_req, rs2_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL prereset_state: got hold/busy22=%b required 11", {hold_req, rs2_busy});
    end
    reset = 1'b1; alu_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({lng_ready, hold_req, w_enable, rs1_busy, rs2_busy, rd_busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL midreset: got ready/hold/we/b4/b22/b20=%b required 100000",
               {lng_ready, hold_req, w_enable, rs1_busy, rs2_busy, rd_busy});
    end
    tick();
    n_tests++;
    if ({w_enable, lng_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL postreset_empty: got we/ready=%b required 01", {w_enable, lng_ready});
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_long();
    test_fill();
    test_stall();
    test_set_clear_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
